// File: rtl/usb_xfer_scheduler.sv
// Multi-channel USB transfer scheduler: per-channel descriptor queues,
// round-robin arbitration and a single shared DMA port with error/timeout tracking.
module usb_xfer_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int QDEPTH     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 1024,
    localparam int CW = $clog2(NUM_CH),
    localparam int LW = $clog2(QDEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   suspend,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic                   desc_valid,
    output logic                   desc_ready,
    input  logic [CW-1:0]          desc_ch,
    input  logic [ADDR_WIDTH-1:0]  desc_addr,
    input  logic [15:0]            desc_len,
    input  logic                   desc_dir,
    output logic                   dma_req,
    input  logic                   dma_ack,
    output logic [ADDR_WIDTH-1:0]  dma_addr,
    output logic [15:0]            dma_length,
    output logic                   dma_write,
    input  logic                   dma_beat,
    input  logic                   dma_err,
    output logic                   cmpl_valid,
    output logic [CW-1:0]          cmpl_ch,
    output logic [1:0]             cmpl_status,
    output logic                   transfer_complete_irq,
    output logic                   error_irq,
    output logic [NUM_CH*LW-1:0]   q_level,
    output logic                   busy,
    output logic [31:0]            transfer_count,
    output logic [31:0]            error_count
);
    localparam int PW    = $clog2(QDEPTH);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           len;
        logic                  dir;
    } desc_t;

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t              state, nxt;
    logic [1:0]          status, nxt_status;
    desc_t               mem [NUM_CH][QDEPTH];
    logic [PW-1:0]       wr_ptr [NUM_CH];
    logic [PW-1:0]       rd_ptr [NUM_CH];
    logic [LW-1:0]       level [NUM_CH];
    logic [NUM_CH-1:0]   elig, push, pop;
    logic                grant;
    logic [CW-1:0]       win, idx;
    logic [CW-1:0]       last_grant, cur_ch;
    desc_t               cur;
    logic [15:0]         beats, beats_init;
    logic [16:0]         len_round;
    logic [TW-1:0]       stall;
    logic                stall_hit;

    // Queue handshake and eligibility, all from registered levels
    always_comb begin
        desc_ready = (level[desc_ch] != LW'(QDEPTH));
        elig = '0;
        push = '0;
        pop  = '0;
        q_level = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = (level[c] != '0) && ch_en[c] && enable && !suspend;
            push[c] = desc_valid && desc_ready && (desc_ch == CW'(c));
            pop[c]  = (state == IDLE) && grant && (win == CW'(c));
            q_level[c*LW +: LW] = level[c];
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        grant = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = CW'((int'(last_grant) + i) % NUM_CH);
            if (!grant && elig[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                level[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
                if (push[c] && !pop[c])      level[c] <= level[c] + LW'(1);
                else if (!push[c] && pop[c]) level[c] <= level[c] - LW'(1);
            end
        end
    end

    // Descriptor storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (desc_valid && desc_ready)
            mem[desc_ch][wr_ptr[desc_ch]] <= '{desc_addr, desc_len, desc_dir};
    end

    assign len_round  = {1'b0, cur.len} + 17'(BYTES - 1);
    assign beats_init = 16'(len_round >> BSH);
    assign stall_hit  = (stall == TW'(TIMEOUT - 1));

    // Next-state and completion status; errors beat the final beat
    always_comb begin
        nxt        = state;
        nxt_status = status;
        case (state)
            IDLE: if (grant) nxt = REQ;
            REQ: begin
                if (dma_err) begin
                    nxt = DONE;
                    nxt_status = ST_ERR;
                end else if (dma_ack) begin
                    if (cur.len == 16'd0) begin
                        nxt = DONE;
                        nxt_status = ST_OK;
                    end else begin
                        nxt = XFER;
                    end
                end else if (stall_hit) begin
                    nxt = DONE;
                    nxt_status = ST_TMO;
                end
            end
            XFER: begin
                if (dma_err) begin
                    nxt = DONE;
                    nxt_status = ST_ERR;
                end else if (dma_beat) begin
                    if (beats == 16'd1) begin
                        nxt = DONE;
                        nxt_status = ST_OK;
                    end
                end else if (stall_hit) begin
                    nxt = DONE;
                    nxt_status = ST_TMO;
                end
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State register, active descriptor, beat/stall tracking and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            status         <= ST_OK;
            cur            <= '0;
            cur_ch         <= '0;
            last_grant     <= CW'(NUM_CH - 1);
            beats          <= '0;
            stall          <= '0;
            transfer_count <= '0;
            error_count    <= '0;
        end else begin
            state  <= nxt;
            status <= nxt_status;
            if (state == IDLE && grant) begin
                cur        <= mem[win][rd_ptr[win]];
                cur_ch     <= win;
                last_grant <= win;
            end
            if (state == REQ && dma_ack)
                beats <= beats_init;
            else if (state == XFER && dma_beat)
                beats <= beats - 16'd1;
            if (nxt != state || (state == XFER && dma_beat))
                stall <= '0;
            else if (state == REQ || state == XFER)
                stall <= stall + TW'(1);
            if (state == DONE) begin
                if (status == ST_OK) transfer_count <= transfer_count + 32'd1;
                else                 error_count    <= error_count + 32'd1;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign dma_req     = (state == REQ);
    assign dma_addr    = cur.addr;
    assign dma_length  = cur.len;
    assign dma_write   = cur.dir;
    assign cmpl_valid  = (state == DONE);
    assign cmpl_ch     = cmpl_valid ? cur_ch : '0;
    assign cmpl_status = cmpl_valid ? status : 2'b00;
    assign transfer_complete_irq = cmpl_valid && (status == ST_OK);
    assign error_irq             = cmpl_valid && (status != ST_OK);

endmodule

// File: tb/tb_usb_xfer_scheduler.sv
// Directed bench for usb_xfer_scheduler: cycle table for single transfers
// plus sequences for fairness, backpressure, timeout, suspend and reset.
module tb_usb_xfer_scheduler;
    localparam int NUM_CH = 4;
    localparam int QDEPTH = 4;
    localparam int TMO    = 16;
    localparam int CW     = 2;
    localparam int LW     = 3;

    logic        clk = 1'b0;
    logic        rst, enable, suspend;
    logic [3:0]  ch_en;
    logic        desc_valid, desc_ready, desc_dir;
    logic [1:0]  desc_ch;
    logic [31:0] desc_addr;
    logic [15:0] desc_len;
    logic        dma_req, dma_ack, dma_write, dma_beat, dma_err;
    logic [31:0] dma_addr;
    logic [15:0] dma_length;
    logic        cmpl_valid;
    logic [1:0]  cmpl_ch, cmpl_status;
    logic        transfer_complete_irq, error_irq, busy;
    logic [11:0] q_level;
    logic [31:0] transfer_count, error_count;

    int checks = 0;
    int errors = 0;

    usb_xfer_scheduler #(
        .NUM_CH(NUM_CH), .QDEPTH(QDEPTH), .ADDR_WIDTH(32),
        .DATA_WIDTH(64), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .suspend(suspend),
        .ch_en(ch_en), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_ch(desc_ch), .desc_addr(desc_addr), .desc_len(desc_len),
        .desc_dir(desc_dir), .dma_req(dma_req), .dma_ack(dma_ack),
        .dma_addr(dma_addr), .dma_length(dma_length), .dma_write(dma_write),
        .dma_beat(dma_beat), .dma_err(dma_err), .cmpl_valid(cmpl_valid),
        .cmpl_ch(cmpl_ch), .cmpl_status(cmpl_status),
        .transfer_complete_irq(transfer_complete_irq), .error_irq(error_irq),
        .q_level(q_level), .busy(busy), .transfer_count(transfer_count),
        .error_count(error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  ch;
        logic [31:0] addr;
        logic [15:0] len;
        logic        dir;
        logic        ack;
        logic        beat;
        logic        err;
        logic [21:0] exp;
    } vec_t;

    vec_t vt[$];

    function automatic logic [21:0] ex(input logic req, input logic bsy,
                                       input logic cv, input logic [1:0] st,
                                       input logic [1:0] cc, input logic ti,
                                       input logic ei, input logic [11:0] ql);
        return {req, bsy, cv, st, cc, ti, ei, ql, 1'b1};
    endfunction

    function automatic logic [21:0] obs();
        return {dma_req, busy, cmpl_valid, cmpl_status, cmpl_ch,
                transfer_complete_irq, error_irq, q_level, desc_ready};
    endfunction

    function automatic vec_t mk(input logic v, input logic [1:0] ch,
                                input logic [31:0] addr, input logic [15:0] len,
                                input logic dir, input logic ack,
                                input logic beat, input logic err,
                                input logic [21:0] e);
        vec_t r;
        r.v = v; r.ch = ch; r.addr = addr; r.len = len; r.dir = dir;
        r.ack = ack; r.beat = beat; r.err = err; r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] addr,
                        input logic [15:0] len, input logic dir);
        desc_valid = 1'b1; desc_ch = ch; desc_addr = addr;
        desc_len = len; desc_dir = dir;
        @(negedge clk);
        desc_valid = 1'b0; desc_ch = 2'd0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!dma_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", dma_req, 1);
    endtask

    task automatic wait_cmpl();
        int n;
        n = 0;
        while (!cmpl_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("cmpl_seen", cmpl_valid, 1);
    endtask

    task automatic serve(input int ch, input logic [31:0] addr,
                         input int nb, input int ql);
        wait_req();
        check("req_addr", dma_addr, addr);
        check("req_qlevel", q_level[ch*LW +: LW], ql);
        dma_ack = 1'b1;
        @(negedge clk);
        dma_ack = 1'b0;
        for (int b = 0; b < nb; b++) begin
            dma_beat = 1'b1;
            @(negedge clk);
            dma_beat = 1'b0;
        end
        wait_cmpl();
        check("cmpl_ch", cmpl_ch, ch);
        check("cmpl_status", cmpl_status, 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        logic saw;

        rst = 1'b1; enable = 1'b1; suspend = 1'b0; ch_en = 4'hF;
        desc_valid = 1'b0; desc_ch = '0; desc_addr = '0; desc_len = '0;
        desc_dir = 1'b0; dma_ack = 1'b0; dma_beat = 1'b0; dma_err = 1'b0;

        // single ch1 transfer, 2 beats
        vt.push_back(mk(1, 1, 32'h1000, 16, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h008)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, ex(0,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, ex(0,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, ex(0,1,1,0,1,1,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h000)));
        // len 0 on ch2 completes right after ack
        vt.push_back(mk(1, 2, 32'h2000, 0, 1, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h040)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, ex(0,1,1,0,2,1,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h000)));
        // len 9 on ch3 needs two beats
        vt.push_back(mk(1, 3, 32'h3000, 9, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h200)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, ex(0,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, ex(0,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, ex(0,1,1,0,3,1,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h000)));
        // error together with final beat on ch0
        vt.push_back(mk(1, 0, 32'h4000, 8, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h001)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, ex(0,1,0,0,0,0,0,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, ex(0,1,1,1,0,0,1,12'h000)));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,12'h000)));
        // stray ack/beat in IDLE are ignored
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, ex(0,0,0,0,0,0,0,12'h000)));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", obs(), ex(0,0,0,0,0,0,0,12'h000));
        check("reset_counts", {transfer_count, error_count}, 0);
        check("reset_addr", dma_addr, 0);

        for (int i = 0; i < vt.size(); i++) begin
            desc_valid = vt[i].v; desc_ch = vt[i].ch; desc_addr = vt[i].addr;
            desc_len = vt[i].len; desc_dir = vt[i].dir; dma_ack = vt[i].ack;
            dma_beat = vt[i].beat; dma_err = vt[i].err;
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(), vt[i].exp);
            if (i == 1) begin
                check("vec1_addr", dma_addr, 32'h1000);
                check("vec1_len", dma_length, 16);
                check("vec1_dir", dma_write, 0);
            end
            if (i == 7) check("vec7_dir", dma_write, 1);
        end
        desc_valid = 0; desc_ch = 0; dma_ack = 0; dma_beat = 0; dma_err = 0;
        check("table_xfer_count", transfer_count, 3);
        check("table_err_count", error_count, 1);

        // timeout with no beats after ack
        push(1, 32'h1100, 16, 0);
        wait_req();
        dma_ack = 1'b1;
        @(negedge clk);
        dma_ack = 1'b0;
        n = 0;
        while (!cmpl_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles", n, TMO);
        check("tmo_status", cmpl_status, 2);
        check("tmo_irq", {error_irq, transfer_complete_irq}, 2'b10);
        @(negedge clk);
        check("tmo_err_count", error_count, 2);

        // fairness from a fresh reset
        do_reset();
        enable = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                push(2'(c), 32'h5000 + 32'(c * 16 + r), 8, 0);
        check("fair_levels", q_level, 12'b010_010_010_010);
        enable = 1'b1;
        for (int k = 0; k < 8; k++)
            serve(k % 4, 32'h5000 + 32'((k % 4) * 16 + k / 4), 1, 1 - k / 4);

        // backpressure on a masked channel
        ch_en = 4'b1011;
        for (int i = 0; i < QDEPTH; i++) push(2, 32'h6000 + 32'(i), 8, 0);
        desc_ch = 2'd2;
        #1;
        check("bp_ready_full", desc_ready, 0);
        desc_ch = 2'd1;
        #1;
        check("bp_ready_other", desc_ready, 1);
        desc_ch = 2'd2;
        desc_valid = 1'b1;
        desc_addr = 32'hDEAD;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (dma_req) saw = 1'b1;
        end
        desc_valid = 1'b0;
        check("bp_no_req", saw, 0);
        check("bp_level", q_level[2*LW +: LW], 4);
        ch_en = 4'hF;
        for (int i = 0; i < QDEPTH; i++) serve(2, 32'h6000 + 32'(i), 1, 3 - i);

        // suspend during XFER lets it finish and holds the next one
        push(0, 32'h7000, 16, 0);
        push(0, 32'h7001, 16, 0);
        wait_req();
        check("sus_addr", dma_addr, 32'h7000);
        dma_ack = 1'b1;
        @(negedge clk);
        dma_ack = 1'b0;
        suspend = 1'b1;
        dma_beat = 1'b1;
        repeat (2) @(negedge clk);
        dma_beat = 1'b0;
        check("sus_cmpl", {cmpl_valid, cmpl_status}, 3'b100);
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dma_req) saw = 1'b1;
        end
        check("sus_no_req", saw, 0);
        suspend = 1'b0;
        @(negedge clk);
        check("sus_resume_req", dma_req, 1);
        serve(0, 32'h7001, 2, 0);
        check("pre_rst_counts", {transfer_count, error_count}, {32'd14, 32'd0});

        // reset in the middle of XFER
        push(2, 32'h8000, 32, 0);
        push(2, 32'h8001, 32, 0);
        wait_req();
        dma_ack = 1'b1;
        @(negedge clk);
        dma_ack = 1'b0;
        dma_beat = 1'b1;
        @(negedge clk);
        dma_beat = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid", {dma_req, busy, cmpl_valid, q_level}, 0);
        rst = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (cmpl_valid || dma_req) saw = 1'b1;
        end
        check("rst_quiet", saw, 0);
        check("rst_counts", {transfer_count, error_count}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_xfer_scheduler.md
# usb_xfer_scheduler

Multi-channel USB transfer scheduler between the USB host controller register file and the shared DMA port. It queues transfer descriptors per channel (one channel per endpoint pipe) and arbitrates round-robin among them, issuing one DMA transfer at a time. It tracks beat progress, DMA errors and stalls, and reports completions, interrupts and statistics counters. It generalises the previous single-queue transfer path to NUM_CH channels with configurable queue depth, per-channel masking, suspend gating and stall timeout.

## Interface
Parameters:
- NUM_CH, 4: number of channels; ≥2. CW = $clog2(NUM_CH).
- QDEPTH, 4: descriptors per channel queue; power of 2, ≥2. LW = $clog2(QDEPTH)+1.
- ADDR_WIDTH, 32: DMA address width.
- DATA_WIDTH, 64: DMA beat width; BYTES = DATA_WIDTH/8.
- TIMEOUT, 1024: stall limit in cycles; ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  run/stop; gates new arbitration only.
- suspend  in  1  gates new arbitration only.
- ch_en  in  NUM_CH  per-channel arbitration enable.
- desc_valid / desc_ready  in / out  1  descriptor push handshake.
- desc_ch  in  CW  target channel.
- desc_addr  in  ADDR_WIDTH  buffer address.
- desc_len  in  16  length in bytes.
- desc_dir  in  1  1 = IN (DMA writes memory).
- dma_req  out  1  transfer request.
- dma_ack  in  1  request accepted.
- dma_addr  out  ADDR_WIDTH  address of the active transfer.
- dma_length  out  16  length of the active transfer.
- dma_write  out  1  direction of the active transfer.
- dma_beat  in  1  one BYTES-wide beat moved.
- dma_err  in  1  DMA fault.
- cmpl_valid  out  1  one-cycle completion pulse.
- cmpl_ch  out  CW  channel of the completion.
- cmpl_status  out  2  00 OK, 01 DMA error, 10 timeout.
- transfer_complete_irq  out  1  one-cycle pulse on OK completion.
- error_irq  out  1  one-cycle pulse on non-OK completion.
- q_level  out  NUM_CH*LW  per-channel occupancy; channel c in bits [c*LW +: LW].
- busy  out  1  FSM not in IDLE.
- transfer_count / error_count  out  32  completion counters; wrap at 2^32.

## Operation
- Queues: one FIFO per channel holding {addr, len, dir}.
  - Push occurs when desc_valid && desc_ready.
  - desc_ready = !full(queue[desc_ch]), computed combinationally from the registered level.
  - Pushes are accepted regardless of enable, suspend and ch_en.
- Eligible channel: queue non-empty && ch_en[c] && enable && !suspend.
- Round-robin: the search starts at last_grant+1 mod NUM_CH. last_grant resets to NUM_CH-1, so channel 0 wins first after reset.
- FSM states: IDLE, REQ, XFER, DONE.
  - IDLE: if any channel is eligible, latch the winner and its head descriptor, pop that queue, update last_grant, and go to REQ.
  - REQ: hold dma_req=1 with dma_addr, dma_length and dma_write stable.
    - On dma_ack, load beats = ceil(len/BYTES) and go to XFER. If len==0, go straight to DONE with status OK.
  - XFER: each dma_beat decrements beats. The beat that brings beats to 0 moves the FSM to DONE with OK.
  - DONE: lasts one cycle. Assert cmpl_valid, cmpl_ch, cmpl_status and the matching IRQ; increment the matching counter; return to IDLE.
- Errors: dma_err in REQ or XFER moves to DONE with status 01. If dma_err and the final beat occur in the same cycle, the error wins.
- Timeout: a stall counter runs in REQ and XFER. It clears on state entry and on every dma_beat. After TIMEOUT consecutive cycles without ack (in REQ) or without a beat (in XFER), go to DONE with status 10.
- Stray inputs: dma_beat outside XFER and dma_ack outside REQ are ignored.
- Mid-transfer changes: suspend, enable or ch_en changing during REQ or XFER does not abort the transfer; it only affects the next arbitration.

## Timing
- Reset values: all outputs 0 except desc_ready, which is 1 whenever the addressed queue is empty. After reset all queues are empty, FSM is in IDLE, counters are 0 and last_grant = NUM_CH-1.
- Reset mid-transfer: sampling rst high drops dma_req and busy on the next edge, discards all queued descriptors and emits no completion.
- Latency from push to request: a descriptor pushed at edge N into an idle scheduler is popped at N+1, and dma_req is high from N+1 (in REQ) until the ack edge.
- Latency from final beat to completion: the final beat sampled at edge M gives cmpl_valid and the IRQ high for the cycle after M, and the FSM is back in IDLE one cycle later.
- Back-to-back transfers: the minimum gap between consecutive dma_req assertions is 2 cycles (DONE, IDLE).
- q_level updates on the edge after a push or pop.

## Test plan
- Single transfer: push ch1, addr 0x1000, len 16, dir 0; ack; 2 beats -> dma_req 1 cycle after push; cmpl ch1, status 00; transfer_complete_irq one pulse; transfer_count=1.
- Fairness: fill ch0..ch3 with 2 descriptors each, every transfer 1 beat -> grant order 0,1,2,3,0,1,2,3; q_levels decrement accordingly.
- Backpressure: with ch_en[2]=0, push QDEPTH descriptors to ch2 -> desc_ready=0 when desc_ch=2; no dma_req; set ch_en[2]=1 -> the 4 transfers drain.
- Errors: dma_err on the same cycle as the final beat -> status 01, error_irq, error_count=1. Separately, no beats for TIMEOUT cycles after ack -> status 10.
- Gating: assert suspend while a transfer is in XFER -> the transfer completes OK, no new dma_req while suspended; deassert -> the next queued transfer starts 1 cycle later.
- Edge cases: len=0 -> DONE right after ack, status 00. len=9 with BYTES=8 -> exactly 2 beats. rst during XFER -> dma_req=0, q_level=0, no cmpl_valid.
